// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int DATA_W       = 64;   // processor data word, fixed
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_WB_DEPTH = 4;
  // Buffer entries store the full 32-bit word address (zero-extended index),
  // so the entry type does not depend on the ADDR_W chosen per instance.
  localparam int ENT_ADDR_W   = 32;

  typedef enum logic [1:0] {REQ_IDLE, REQ_RD, REQ_WR} req_e;

  typedef struct packed {
    logic                  valid;
    logic [ENT_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_ent_t;

  function automatic req_e classify(input logic en, input logic we);
    if (!en)     return REQ_IDLE;
    else if (we) return REQ_WR;
    else         return REQ_RD;
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// Coalescing write buffer: circular FIFO with a parallel address match used
// both to merge repeat writes and to forward pending data to reads. The head
// entry drains on idle cycles, or is forced out when a new address arrives
// while the buffer is full.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter  int ADDR_W   = DEF_ADDR_W,
  parameter  int WB_DEPTH = DEF_WB_DEPTH,
  localparam int PW       = $clog2(WB_DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  req_e              req,
  input  logic              addr_ok,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              drain_vld,
  output logic [ADDR_W-1:0] drain_addr,
  output logic [DATA_W-1:0] drain_data,
  output logic [CW-1:0]     count
);

  wb_ent_t               ent [WB_DEPTH];
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         cnt;
  logic [WB_DEPTH-1:0]   hit;
  logic [PW-1:0]         hit_idx;
  logic [ENT_ADDR_W-1:0] addr_x;
  logic                  full, wr, do_coal, do_push, force_drain, idle_drain;

  assign addr_x = ENT_ADDR_W'(addr);

  for (genvar i = 0; i < WB_DEPTH; i++) begin : g_match
    assign hit[i] = ent[i].valid && (ent[i].addr == addr_x);
  end

  // Addresses are unique in the buffer, so at most one hit bit is set.
  always_comb begin
    hit_idx  = '0;
    fwd_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (hit[i]) begin
        hit_idx  = PW'(i);
        fwd_data = ent[i].data;
      end
    end
  end

  assign fwd_hit     = |hit;
  assign full        = (cnt == CW'(WB_DEPTH));
  assign wr          = (req == REQ_WR) && addr_ok;
  assign do_coal     = wr && fwd_hit;
  assign do_push     = wr && !fwd_hit;
  assign force_drain = do_push && full;
  assign idle_drain  = (req == REQ_IDLE) && (cnt != '0);

  assign drain_vld   = force_drain || idle_drain;
  assign drain_addr  = ent[head].addr[ADDR_W-1:0];
  assign drain_data  = ent[head].data;
  assign count       = cnt;

  // FIFO update; on a forced drain head==tail, so the new entry reuses the
  // slot that drains on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < WB_DEPTH; i++) ent[i] <= '0;
    end else begin
      if (do_coal)    ent[hit_idx].data <= wr_data;
      if (do_push) begin
        ent[tail] <= '{valid: 1'b1, addr: addr_x, data: wr_data};
        tail      <= tail + 1'b1;
      end
      if (idle_drain) ent[head].valid <= 1'b0;
      if (drain_vld)  head <= head + 1'b1;
      if (do_push && !full) cnt <= cnt + 1'b1;
      else if (idle_drain)  cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the processor data port: word array behind a
// coalescing write buffer, one-cycle registered read data, address-range
// error pulse. Optional request counters under DMEM_STATS_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter  int ADDR_W   = DEF_ADDR_W,
  parameter  int WB_DEPTH = DEF_WB_DEPTH,
  localparam int CW       = $clog2(WB_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memEn,
  input  logic              memWrEn,
  input  logic [31:0]       memAddr,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData,
  output logic              rdValid,
  output logic              addrErr,
  output logic [CW-1:0]     wbCount,
  output logic [31:0]       statRdCnt,
  output logic [31:0]       statWrCnt
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  req_e              req;
  logic              addr_ok;
  logic [ADDR_W-1:0] idx;
  logic              fwd_hit, drain_vld;
  logic [DATA_W-1:0] fwd_data, drain_data;
  logic [ADDR_W-1:0] drain_addr;

  assign req     = classify(memEn, memWrEn);
  assign addr_ok = (memAddr[31:ADDR_W] == '0);
  assign idx     = memAddr[ADDR_W-1:0];

  dmem_wbuf #(.ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH)) u_wbuf (
    .clk        (clk),
    .rst        (reset),
    .req        (req),
    .addr_ok    (addr_ok),
    .addr       (idx),
    .wr_data    (wrData),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .drain_vld  (drain_vld),
    .drain_addr (drain_addr),
    .drain_data (drain_data),
    .count      (wbCount)
  );

  // Array write port, fed only by buffer drains; contents survive reset.
  always_ff @(posedge clk) begin
    if (drain_vld) mem[drain_addr] <= drain_data;
  end

  // Registered response; buffered data wins over the (stale) array word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdData  <= '0;
      rdValid <= 1'b0;
      addrErr <= 1'b0;
    end else begin
      rdValid <= (req == REQ_RD);
      addrErr <= memEn && !addr_ok;
      if (req == REQ_RD)
        rdData <= !addr_ok ? '0 : (fwd_hit ? fwd_data : mem[idx]);
    end
  end

`ifdef DMEM_STATS_EN
  // Saturating counts of in-range reads and writes (coalesced writes count).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      statRdCnt <= '0;
      statWrCnt <= '0;
    end else begin
      if (addr_ok && req == REQ_RD && statRdCnt != '1) statRdCnt <= statRdCnt + 1'b1;
      if (addr_ok && req == REQ_WR && statWrCnt != '1) statWrCnt <= statWrCnt + 1'b1;
    end
  end
`else
  assign statRdCnt = '0;
  assign statWrCnt = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand sequences for reset
// and counters, then random traffic against a queue-level reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memEn = 1'b0, memWrEn = 1'b0;
  logic [31:0] memAddr = '0;
  logic [63:0] wrData = '0;
  logic [63:0] rdData;
  logic        rdValid, addrErr;
  logic [2:0]  wbCount;
  logic [31:0] statRdCnt, statWrCnt;

  int checks = 0;
  int errors = 0;

  dmem_responder dut (
    .clk(clk), .reset(reset), .memEn(memEn), .memWrEn(memWrEn),
    .memAddr(memAddr), .wrData(wrData), .rdData(rdData), .rdValid(rdValid),
    .addrErr(addrErr), .wbCount(wbCount), .statRdCnt(statRdCnt), .statWrCnt(statWrCnt)
  );

  always #5 clk = ~clk;

  // Reference model: committed array image plus an ordered list of pending
  // writes (oldest first); what a read sees is the pending value if present.
  typedef struct { int a; logic [63:0] d; } pend_t;
  logic [63:0] arr [256];
  pend_t       q[$];
  logic [63:0] m_rd;
  bit          m_v, m_err;
  int          m_rds, m_wrs;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd = '0; m_v = 0; m_err = 0; m_rds = 0; m_wrs = 0;
  endtask

  task automatic model_req(input bit en, input bit we, input logic [31:0] a, input logic [63:0] d);
    bit oor;
    bit found;
    int ix;
    oor   = (a[31:8] != 0);
    ix    = int'(a[7:0]);
    m_err = en && oor;
    m_v   = en && !we;
    if (en && !we) begin
      if (oor) m_rd = '0;
      else begin
        m_rds++;
        m_rd = arr[ix];
        foreach (q[k]) if (q[k].a == ix) m_rd = q[k].d;
      end
    end
    if (en && we && !oor) begin
      m_wrs++;
      found = 0;
      foreach (q[k]) if (q[k].a == ix) begin q[k].d = d; found = 1; end
      if (!found) begin
        if (q.size() == 4) begin
          arr[q[0].a] = q[0].d;
          void'(q.pop_front());
        end
        q.push_back('{ix, d});
      end
    end
    if (!en && q.size() > 0) begin
      arr[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
  endtask

  // One request cycle: drive, advance the model, clock, compare.
  task automatic cyc(input bit en, input bit we, input logic [31:0] a, input logic [63:0] d);
    memEn = en; memWrEn = we; memAddr = a; wrData = d;
    model_req(en, we, a, d);
    @(posedge clk); #1;
    chk("rdValid", 64'(rdValid), 64'(m_v));
    chk("addrErr", 64'(addrErr), 64'(m_err));
    chk("wbCount", 64'(wbCount), 64'(q.size()));
    chk("rdData",  rdData, m_rd);
`ifdef DMEM_STATS_EN
    chk("statRdCnt", 64'(statRdCnt), 64'(m_rds));
    chk("statWrCnt", 64'(statWrCnt), 64'(m_wrs));
`else
    chk("statRdCnt", 64'(statRdCnt), 64'd0);
    chk("statWrCnt", 64'(statWrCnt), 64'd0);
`endif
  endtask

  // Asynchronous assert mid-cycle, release away from the clock edge.
  task automatic do_reset();
    memEn = 0; memWrEn = 0;
    reset = 1'b1;
    #2;
    chk("rst_wbCount", 64'(wbCount), 64'd0);
    chk("rst_rdValid", 64'(rdValid), 64'd0);
    chk("rst_addrErr", 64'(addrErr), 64'd0);
    chk("rst_rdData",  rdData, 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
  endtask

  typedef struct {
    bit          en, we;
    logic [31:0] addr;
    logic [63:0] data;
    bit          ev, eerr;
    logic [63:0] erd;
    int          ecnt;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(bit en, bit we, logic [31:0] a, logic [63:0] d,
                              bit ev, logic [63:0] erd, bit eerr, int ecnt);
    vec_t v;
    v.en = en; v.we = we; v.addr = a; v.data = d;
    v.ev = ev; v.erd = erd; v.eerr = eerr; v.ecnt = ecnt;
    return v;
  endfunction

  initial begin
    model_reset();
    do_reset();

    // Known array image: every word written then fully drained.
    for (int a = 0; a < 256; a++) cyc(1, 1, 32'(a), 64'h1000_0000_0000_0000 | 64'(a));
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);

    tv.push_back(mk(1,1,32'd3,64'hDEADBEEF00000001, 0,64'h0,0,1));
    tv.push_back(mk(1,0,32'd3,64'h0,               1,64'hDEADBEEF00000001,0,1));
    tv.push_back(mk(0,0,32'd0,64'h0,               0,64'h0,0,0));
    tv.push_back(mk(1,1,32'd7,64'hA,               0,64'h0,0,1));
    tv.push_back(mk(1,1,32'd7,64'hB,               0,64'h0,0,1));
    tv.push_back(mk(0,0,32'd0,64'h0,               0,64'h0,0,0));
    tv.push_back(mk(0,0,32'd0,64'h0,               0,64'h0,0,0));
    tv.push_back(mk(1,0,32'd7,64'h0,               1,64'hB,0,0));
    for (int i = 1; i <= 5; i++)
      tv.push_back(mk(1,1,32'(i),64'(i*16),        0,64'h0,0,(i < 4) ? i : 4));
    for (int i = 1; i <= 5; i++)
      tv.push_back(mk(1,0,32'(i),64'h0,            1,64'(i*16),0,4));
    tv.push_back(mk(1,0,32'h0001_0002,64'h0,       1,64'h0,1,4));
    tv.push_back(mk(1,1,32'h0001_0002,64'hFFFF,    0,64'h0,1,4));
    tv.push_back(mk(1,0,32'd2,64'h0,               1,64'h20,0,4));
    tv.push_back(mk(1,0,32'd9,64'h0,               1,64'h1000_0000_0000_0009,0,4));

    foreach (tv[i]) begin
      cyc(tv[i].en, tv[i].we, tv[i].addr, tv[i].data);
      chk($sformatf("tv%0d_rdValid", i), 64'(rdValid), 64'(tv[i].ev));
      chk($sformatf("tv%0d_addrErr", i), 64'(addrErr), 64'(tv[i].eerr));
      chk($sformatf("tv%0d_wbCount", i), 64'(wbCount), 64'(tv[i].ecnt));
      if (tv[i].ev) chk($sformatf("tv%0d_rdData", i), rdData, tv[i].erd);
    end

    // Pending write lost on reset; array keeps its drained value.
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    cyc(1, 1, 32'd5, 64'h11);
    do_reset();
    chk("rstlost_wbCount", 64'(wbCount), 64'd0);
    cyc(1, 0, 32'd5, 64'h0);
    chk("rstlost_rdData", rdData, 64'h50);

    // Counter sequence from a fresh reset.
    do_reset();
    cyc(1, 0, 32'd1, 0); cyc(1, 0, 32'd2, 0); cyc(1, 0, 32'd3, 0);
    cyc(1, 1, 32'd4, 64'h44); cyc(1, 1, 32'd5, 64'h55);
    cyc(1, 0, 32'h0000_0100, 0);
`ifdef DMEM_STATS_EN
    chk("stat_rd", 64'(statRdCnt), 64'd3);
    chk("stat_wr", 64'(statWrCnt), 64'd2);
`else
    chk("stat_rd", 64'(statRdCnt), 64'd0);
    chk("stat_wr", 64'(statWrCnt), 64'd0);
`endif

    // Random traffic over a small address window to provoke hits and
    // coalescing, with occasional out-of-range requests.
    for (int n = 0; n < 3000; n++) begin
      bit          en, we;
      logic [31:0] a;
      en = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) a = (32'($urandom_range(1, 16'hFFFF)) << 16) | 32'($urandom_range(0, 11));
      else                            a = 32'($urandom_range(0, 11));
      cyc(en, we, a, {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
